// File: rtl/acc_iq_avg_pkg.sv
// rtl/acc_iq_avg_pkg.sv - shared types and constants for the I/Q averager.
// Optional feature macro: ACC_IQ_AVG_ROUND_EN (round half-up with saturation).
package acc_iq_avg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int STAT_BUSY = 31;
  localparam int STAT_PEND = 30;
  localparam int STAT_OVR  = 29;
  localparam int STAT_CONT = 28;

  // Sum of 2^log2_navg samples of data_w bits always fits in data_w+log2_navg bits.
  function automatic int acc_width(input int data_w, input int log2_navg);
    return data_w + log2_navg;
  endfunction

endpackage

// File: rtl/acc_iq_avg_lane.sv
// rtl/acc_iq_avg_lane.sv - one signed accumulator with shift (and optional round/saturate).
// Optional feature macro: ACC_IQ_AVG_ROUND_EN.
module acc_iq_avg_lane
  import acc_iq_avg_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LOG2_NAVG = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_add,
  input  logic                     i_last,
  input  logic signed [DATA_W-1:0] i_sample,
  output logic signed [DATA_W-1:0] o_avg
);

  localparam int ACC_W = acc_width(DATA_W, LOG2_NAVG);

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_avg;
  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [DATA_W-1:0] w_res;

  assign w_ext = {{LOG2_NAVG{i_sample[DATA_W-1]}}, i_sample};
  assign w_sum = r_acc + w_ext;

`ifdef ACC_IQ_AVG_ROUND_EN
  localparam int RW = ACC_W + 1;
  localparam logic [RW-1:0] C_HALF = RW'(1) << (LOG2_NAVG - 1);
  localparam logic [RW-1:0] C_MAX  = {{(RW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};

  logic signed [RW-1:0] w_rnd;
  logic signed [RW-1:0] w_shift;

  // One extra bit keeps the rounding add exact; only the positive side can exceed range.
  assign w_rnd   = $signed({w_sum[ACC_W-1], w_sum}) + $signed(C_HALF);
  assign w_shift = w_rnd >>> LOG2_NAVG;
  assign w_res   = (w_shift > $signed(C_MAX)) ? C_MAX[DATA_W-1:0] : w_shift[DATA_W-1:0];
`else
  assign w_res = DATA_W'(w_sum >>> LOG2_NAVG);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_avg <= '0;
    end else begin
      if (i_last) begin
        r_acc <= '0;
        r_avg <= w_res;
      end else if (i_clr) begin
        r_acc <= i_add ? w_ext : '0;
      end else if (i_add) begin
        r_acc <= w_sum;
      end
    end
  end

  assign o_avg = r_avg;

endmodule

// File: rtl/acc_iq_avg_core.sv
// rtl/acc_iq_avg_core.sv - I/Q frame averager with valid/ready result and ss_status word.
// Optional feature macro: ACC_IQ_AVG_ROUND_EN (passed through to the lanes).
module acc_iq_avg_core
  import acc_iq_avg_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LOG2_NAVG = 10,
  parameter int CNT_W     = 16
) (
  input  logic                     user_clk,
  input  logic                     user_rst_n,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_i,
  input  logic signed [DATA_W-1:0] in_q,
  output logic                     avg_valid,
  input  logic                     avg_ready,
  output logic signed [DATA_W-1:0] avg_i,
  output logic signed [DATA_W-1:0] avg_q,
  output logic [31:0]              status
);

  localparam logic [LOG2_NAVG-1:0] C_LAST = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LOG2_NAVG-1:0] r_cnt;
  logic [CNT_W-1:0]     r_res_cnt;
  logic                 r_ovr;
  logic [31:0]          r_status;
  logic [31:0]          w_status;

  logic w_add;
  logic w_last;
  logic w_hs;
  logic w_drop;
  logic w_clr;

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = ACC;
      ACC: begin
        if (start)       w_state_nxt = ACC;
        else if (w_last) w_state_nxt = HOLD;
      end
      HOLD: begin
        if (start)     w_state_nxt = ACC;
        else if (w_hs) w_state_nxt = cont ? ACC : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // start always wins: it suppresses sample acceptance, the last-sample capture and the handshake.
  always_comb begin
    w_add  = 1'b0;
    w_last = 1'b0;
    w_hs   = 1'b0;
    w_drop = 1'b0;
    case (r_state)
      ACC: begin
        if (!start && in_valid) begin
          w_add  = 1'b1;
          w_last = (r_cnt == C_LAST);
        end
      end
      HOLD: begin
        if (!start) begin
          w_hs = avg_ready;
          if (in_valid) begin
            if (avg_ready && cont) w_add  = 1'b1;
            else                   w_drop = 1'b1;
          end
        end
      end
      default: ;
    endcase
    w_clr = start | w_hs;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_cnt     <= '0;
      r_res_cnt <= '0;
      r_ovr     <= 1'b0;
    end else begin
      if (w_clr)      r_cnt <= w_add ? LOG2_NAVG'(1) : '0;
      else if (w_add) r_cnt <= r_cnt + LOG2_NAVG'(1);

      if (w_hs) r_res_cnt <= r_res_cnt + CNT_W'(1);

      if (start)       r_ovr <= 1'b0;
      else if (w_drop) r_ovr <= 1'b1;
    end
  end

  always_comb begin
    w_status             = '0;
    w_status[STAT_BUSY]  = (r_state != IDLE);
    w_status[STAT_PEND]  = (r_state == HOLD);
    w_status[STAT_OVR]   = r_ovr;
    w_status[STAT_CONT]  = cont;
    w_status[CNT_W-1:0]  = r_res_cnt;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) r_status <= '0;
    else             r_status <= w_status;
  end

  acc_iq_avg_lane #(
    .DATA_W   (DATA_W),
    .LOG2_NAVG(LOG2_NAVG)
  ) u_lane_i (
    .clk     (user_clk),
    .rst_n   (user_rst_n),
    .i_clr   (w_clr),
    .i_add   (w_add),
    .i_last  (w_last),
    .i_sample(in_i),
    .o_avg   (avg_i)
  );

  acc_iq_avg_lane #(
    .DATA_W   (DATA_W),
    .LOG2_NAVG(LOG2_NAVG)
  ) u_lane_q (
    .clk     (user_clk),
    .rst_n   (user_rst_n),
    .i_clr   (w_clr),
    .i_add   (w_add),
    .i_last  (w_last),
    .i_sample(in_q),
    .o_avg   (avg_q)
  );

  assign avg_valid = (r_state == HOLD);
  assign status    = r_status;

endmodule
